sm_adder_arbiter: RTL and testbench
===================================

# sm_adder_arbiter

Round-robin arbiter that shares one combinational 21-bit sign-magnitude adder (`SignedAdder`) among `NREQ` requesters in the ANC datapath, such as LMS tap-update, error-sum and anti-noise mixing stages. Each requester presents an operand pair with a valid/ready handshake. The winner's sum is registered and returned on one result channel tagged with the requester index. The block accepts at most one operation per cycle.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 21: word width, sign-magnitude; bit W-1 is the sign, bits W-2:0 are the magnitude.
- `IDW`, $clog2(NREQ): width of the requester tag.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester operand pair valid.
- `req_ready`  out  NREQ  one-hot grant; a transfer occurs when valid && ready.
- `req_a`  in  NREQ*W  packed operand A; requester i at [i*W +: W].
- `req_b`  in  NREQ*W  packed operand B; same packing as `req_a`.
- `res_valid`  out  1  result register holds a result.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  W  sign-magnitude sum.
- `res_id`  out  IDW  index of the requester that issued the sum.
- `res_ovf`  out  1  magnitude overflow flag (only with the macro; otherwise tied to 0).

## Operation
- Output stage is one register, `slot_full`, plus data, id and ovf.
- `can_issue = !slot_full || res_ready`.
- The grant is issued only when `can_issue` is true and at least one `req_valid` is high.
- Grant rule: the first requester with valid set, searching upward from `rr_ptr` with wrap-around.
- At most one `req_ready` bit is high, and only for a valid requester. `req_ready` is combinational from `req_valid`, `rr_ptr` and `can_issue`.
- On a transfer:
  - the granted a/b pass through `SignedAdder`; the sum, id and ovf are loaded into the register;
  - `slot_full` is set to 1;
  - `rr_ptr` becomes (granted index + 1) mod NREQ.
- Drain without a new transfer (res_valid && res_ready): `slot_full` is cleared to 0.
- Simultaneous drain and transfer: the register is reloaded and `slot_full` stays 1, giving full throughput.
- Backpressure: while `slot_full && !res_ready`, all `req_ready` are 0 and the register holds. Requesters must hold valid, a and b stable until ready.
- Negative zero normalisation: a result with magnitude 0 is output with sign 0. This covers (+x)+(-x) and (-0)+(-0).
- Inputs of -0 are treated as 0.
- `rr_ptr` only advances on a transfer. It does not change on idle cycles.

## Timing
- Latency is one cycle: a transfer at edge k gives `res_valid`/`res_data` visible after edge k.
- Throughput is one result per cycle per block. No requester waits more than NREQ-1 grants while it holds valid.
- Reset values: `slot_full`=0, `res_valid`=0, `res_data`=0, `res_id`=0, `res_ovf`=0, `rr_ptr`=0, `req_ready`=0 (no valid inputs assumed at reset).
- Reset mid-operation: an unconsumed result is discarded with no replay. The arbiter restarts from requester 0 on the first edge after `rst_n` rises.

## Configuration
- Macro: `SM_ADDER_ARB_SAT_EN`.
- Defined: when the operands have the same sign and the magnitude sum is 2^(W-1) or more, the block outputs that sign with magnitude 2^(W-1)-1 and sets `res_ovf`=1. Otherwise `res_ovf`=0.
- Not defined: the `SignedAdder` output passes through unmodified (magnitude wraps mod 2^(W-1)). `res_ovf` is constant 0, and the overflow logic is not synthesised.

## Structure
- Shared package `anc_pkg` holds:
  - `ANC_W`=21;
  - the sign-bit index;
  - `SM_NEG_ZERO`=21'h100000;
  - `SM_MAX_POS`=21'h0FFFFF;
  - a sign-magnitude word typedef.
- The block instantiates the existing `SignedAdder` unchanged.
- One new sub-module, `rr_grant`, contains only the round-robin priority search (valid vector and pointer in, one-hot grant out). It is reused by later ANC arbiters.

## Test plan
- Single requester 0: a=22, b=1048596 (-20) -> one cycle later `res_valid`=1, `res_data`=2, `res_id`=0. `rr_ptr` becomes 1.
- All four valid continuously, `res_ready`=1, requester i sends (450, 234) -> 684 every cycle, with grant order 0,1,2,3,0 and no bubbles.
- Requester 2 sends a=1049026 (-450), b=1048810 (-234) -> 1049260 (-684). Then a=1048598 (-22), b=22 -> 0 (not 1048576).
- Hold `res_ready`=0 for 5 cycles with requesters 1 and 3 valid:
  - `req_ready` stays 0 and the result stays stable;
  - on release, the register drains and requester 1 is granted in the same cycle, then requester 3.
- With `SM_ADDER_ARB_SAT_EN`: a=1048575, b=1 -> `res_data`=1048575, `res_ovf`=1. a=-1048575, b=-5 -> 2097151, `res_ovf`=1. Without the macro: `res_ovf`=0.
- Assert `rst_n`=0 asynchronously while `slot_full`=1 -> `res_valid` drops immediately. After release, the first grant goes to requester 0 even if `rr_ptr` was 2.

Source files
------------

// File: rtl/anc_pkg.sv
// Shared ANC datapath definitions: sign-magnitude word width, sign-bit
// position, the special encodings and the word typedef.
package anc_pkg;
  localparam int ANC_W   = 21;
  localparam int SM_SIGN = ANC_W - 1;

  localparam logic [ANC_W-1:0] SM_NEG_ZERO = 21'h100000;
  localparam logic [ANC_W-1:0] SM_MAX_POS  = 21'h0FFFFF;

  typedef logic [ANC_W-1:0] smWord_t;
endpackage

// File: rtl/SignedAdder.sv
// Combinational sign-magnitude adder. A -0 input is treated as +0, the
// magnitude wraps mod 2^(W-1), and a zero-magnitude result always has sign 0.
module SignedAdder #(
  parameter int W = 21
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  logic [W-2:0] magA, magB, mag;
  logic         sgnA, sgnB, sgn;

  // add on equal signs, otherwise subtract the smaller magnitude
  always_comb begin
    magA = a[W-2:0];
    magB = b[W-2:0];
    sgnA = a[W-1] & (|magA);
    sgnB = b[W-1] & (|magB);
    if (sgnA == sgnB) begin
      mag = magA + magB;
      sgn = sgnA;
    end else if (magA >= magB) begin
      mag = magA - magB;
      sgn = sgnA;
    end else begin
      mag = magB - magA;
      sgn = sgnB;
    end
    sum = {sgn & (|mag), mag};
  end
endmodule

// File: rtl/rr_grant.sv
// Round-robin priority search: first set bit of valid at or above ptr,
// wrapping around. Output is one-hot, or zero when nothing is valid.
module rr_grant #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);
  logic [2*N-1:0] rot, back;
  logic [N-1:0]   low, pri;

  // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
  always_comb begin
    rot   = {valid, valid} >> ptr;
    low   = rot[N-1:0];
    pri   = low & (~low + 1'b1);
    back  = {{N{1'b0}}, pri} << ptr;
    grant = back[N-1:0] | back[2*N-1:N];
  end
endmodule

// File: rtl/sm_adder_arbiter.sv
// Round-robin arbiter sharing one SignedAdder among NREQ requesters with a
// single registered result slot. Optional saturation: SM_ADDER_ARB_SAT_EN.
module sm_adder_arbiter
  import anc_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ANC_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_data,
  output logic [IDW-1:0]    res_id,
  output logic              res_ovf
);
  logic            slotFull, canIssue, xfer;
  logic [IDW-1:0]  rrPtr, grantIdx, nextPtr, idQ;
  logic [NREQ-1:0] grant;
  logic [W-1:0]    opA, opB, addSum, sumOut, dataQ;

  // a new result may enter when the slot is empty or being drained now
  assign canIssue  = !slotFull || res_ready;
  assign xfer      = |grant;
  assign req_ready = grant;

  rr_grant #(.N(NREQ), .PW(IDW)) uGrant (
    .valid (req_valid & {NREQ{canIssue}}),
    .ptr   (rrPtr),
    .grant (grant)
  );

  // steer the winner's operands to the adder and compute the next pointer
  always_comb begin
    grantIdx = '0;
    opA      = '0;
    opB      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grantIdx = IDW'(i);
        opA      = req_a[i*W +: W];
        opB      = req_b[i*W +: W];
      end
    end
    nextPtr = (int'(grantIdx) == NREQ - 1) ? '0 : grantIdx + 1'b1;
  end

  SignedAdder #(.W(W)) uAdd (
    .a   (opA),
    .b   (opB),
    .sum (addSum)
  );

`ifdef SM_ADDER_ARB_SAT_EN
  logic [W-1:0] magSum;
  logic         ovf, ovfQ;

  // clamp same-sign magnitude overflow to the largest magnitude
  always_comb begin
    magSum = {1'b0, opA[W-2:0]} + {1'b0, opB[W-2:0]};
    ovf    = (opA[W-1] == opB[W-1]) && magSum[W-1];
    sumOut = ovf ? {opA[W-1], {(W-1){1'b1}}} : addSum;
  end

  // overflow flag travels with the result it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovfQ <= 1'b0;
    else if (xfer) ovfQ <= ovf;
  end

  assign res_ovf = ovfQ;
`else
  assign sumOut  = addSum;
  assign res_ovf = 1'b0;
`endif

  // result slot and pointer: load on transfer, clear on drain-only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotFull <= 1'b0;
      dataQ    <= '0;
      idQ      <= '0;
      rrPtr    <= '0;
    end else if (xfer) begin
      slotFull <= 1'b1;
      dataQ    <= sumOut;
      idQ      <= grantIdx;
      rrPtr    <= nextPtr;
    end else if (res_ready) begin
      slotFull <= 1'b0;
    end
  end

  assign res_valid = slotFull;
  assign res_data  = dataQ;
  assign res_id    = idQ;
endmodule

// File: tb/tb_sm_adder_arbiter.sv
// Directed bench for sm_adder_arbiter: vector table of single operations plus
// round-robin, backpressure and async-reset sequences.
module tb_sm_adder_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 21;
  localparam int IDW  = 2;

  logic              clk, rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              res_valid, res_ready, res_ovf;
  logic [W-1:0]      res_data;
  logic [IDW-1:0]    res_id;

  int nTests = 0;
  int nFail  = 0;

  sm_adder_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ovf   (res_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expData;
    logic        expOvf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic setLane(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
  endtask

  task automatic doOne(input vec_t v);
    @(posedge clk); #1;
    setLane(v.id, v.a, v.b);
    req_valid = NREQ'(1 << v.id);
    @(negedge clk);
    check("vec_ready", 32'(req_ready), 32'(1 << v.id));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("vec_valid", 32'(res_valid), 32'd1);
    check("vec_data",  32'(res_data),  32'(v.expData));
    check("vec_id",    32'(res_id),    32'(v.id));
    check("vec_ovf",   32'(res_ovf),   32'(v.expOvf));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;

`ifdef SM_ADDER_ARB_SAT_EN
    vecs[5] = '{0, 21'd1048575, 21'd1,       21'd1048575, 1'b1};
    vecs[6] = '{1, 21'h1FFFFF,  21'h100005,  21'd2097151, 1'b1};
`else
    vecs[5] = '{0, 21'd1048575, 21'd1,       21'd0,       1'b0};
    vecs[6] = '{1, 21'h1FFFFF,  21'h100005,  21'h100004,  1'b0};
`endif
    vecs[0] = '{0, 21'd22,      21'd1048596, 21'd2,       1'b0};
    vecs[1] = '{2, 21'd1049026, 21'd1048810, 21'd1049260, 1'b0};
    vecs[2] = '{2, 21'd1048598, 21'd22,      21'd0,       1'b0};
    vecs[3] = '{1, 21'd450,     21'd234,     21'd684,     1'b0};
    vecs[4] = '{3, 21'h100000,  21'h100000,  21'd0,       1'b0};
    vecs[7] = '{2, 21'd5,       21'h100009,  21'h100004,  1'b0};
    vecs[8] = '{3, 21'h100000,  21'd7,       21'd7,       1'b0};

    // reset state
    #12;
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_data",  32'(res_data),  32'd0);
    check("rst_id",    32'(res_id),    32'd0);
    check("rst_ovf",   32'(res_ovf),   32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) doOne(vecs[i]);

    // all four valid continuously: grants 0,1,2,3,0 with no bubbles
    for (int i = 0; i < NREQ; i++) setLane(i, 21'd450, 21'd234);
    @(posedge clk); #1;
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) begin
        check("rr_valid", 32'(res_valid), 32'd1);
        check("rr_id",    32'(res_id),    32'((k - 1) % 4));
        check("rr_data",  32'(res_data),  32'd684);
      end
      @(posedge clk); #1;
    end

    // backpressure with requesters 1 and 3 valid
    req_valid = 4'b1010; res_ready = 1'b0;
    setLane(1, 21'd100, 21'd23);
    setLane(3, 21'h100064, 21'd30);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_id",    32'(res_id),    32'd0);
      check("bp_data",  32'(res_data),  32'd684);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("rel_ready1", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    @(negedge clk);
    check("rel_id1",    32'(res_id),    32'd1);
    check("rel_data1",  32'(res_data),  32'd123);
    check("rel_ready3", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("rel_id3",   32'(res_id),    32'd3);
    check("rel_data3", 32'(res_data),  32'h100046);
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_valid", 32'(res_valid), 32'd0);

    // async reset mid-operation, with rr pointer moved to 2
    res_ready = 1'b0;
    req_valid = 4'b0010;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("pre_rst_valid", 32'(res_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(res_valid), 32'd0);
    check("async_id",    32'(res_id),    32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    setLane(0, 21'd1, 21'd2);
    req_valid = '1; res_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("post_rst_valid", 32'(res_valid), 32'd1);
    check("post_rst_id",    32'(res_id),    32'd0);
    check("post_rst_data",  32'(res_data),  32'd3);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
